// File: rtl/cnn_skip_fork.sv
// rtl/cnn_skip_fork.sv - residual branch fork: registered main path plus skip FIFO.
// Optional sticky overflow/underflow status built only with CNN_SKIP_FORK_STATUS_EN.
module cnn_skip_fork #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int FRAME_SIZE = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] in,
  output logic [DATA_WIDTH-1:0] out_main,
  output logic                  valid_out_main,
  output logic                  frame_end_main,
  input  logic                  rd_en_skip,
  output logic [DATA_WIDTH-1:0] out_skip,
  output logic                  valid_out_skip,
  output logic                  skip_full,
  output logic                  skip_empty,
  output logic [ADDR_WIDTH:0]   skip_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int FW    = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [FW-1:0] LAST_PIX = FW'(FRAME_SIZE - 1);

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [FW-1:0]         r_frame_cnt;
  logic [DATA_WIDTH-1:0] r_out_main;
  logic                  r_valid_main;
  logic                  r_frame_end;
  logic [DATA_WIDTH-1:0] r_out_skip;
  logic                  r_valid_skip;

  logic w_full;
  logic w_empty;
  logic w_rd_ok;
  logic w_wr_ok;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  assign w_rd_ok = rd_en_skip && !w_empty;
  // A granted read frees a slot, so a write into a full FIFO still lands.
  assign w_wr_ok = valid_in && (!w_full || w_rd_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_main   <= '0;
      r_valid_main <= 1'b0;
      r_frame_end  <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_valid_main <= valid_in;
      r_frame_end  <= valid_in && (r_frame_cnt == LAST_PIX);
      if (valid_in) begin
        r_out_main  <= in;
        r_frame_cnt <= (r_frame_cnt == LAST_PIX) ? '0 : r_frame_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_wr_ok) r_mem[r_wr_ptr] <= in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_out_skip   <= '0;
      r_valid_skip <= 1'b0;
    end else begin
      r_valid_skip <= w_rd_ok;
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) begin
        r_out_skip <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef CNN_SKIP_FORK_STATUS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (valid_in && !w_wr_ok) r_overflow <= 1'b1;
      if (rd_en_skip && w_empty) r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign out_main       = r_out_main;
  assign valid_out_main = r_valid_main;
  assign frame_end_main = r_frame_end;
  assign out_skip       = r_out_skip;
  assign valid_out_skip = r_valid_skip;
  assign skip_count     = r_count;
  assign skip_full      = w_full;
  assign skip_empty     = w_empty;

endmodule

// File: tb/tb_cnn_skip_fork.sv
// tb/tb_cnn_skip_fork.sv - vector table plus queue-model random bench for cnn_skip_fork.
module tb_cnn_skip_fork;

  localparam int DW = 32;
  localparam int AW = 2;
  localparam int FS = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic [DW-1:0] din;
  logic          rd_en_skip;
  logic [DW-1:0] out_main;
  logic          valid_out_main;
  logic          frame_end_main;
  logic [DW-1:0] out_skip;
  logic          valid_out_skip;
  logic          skip_full;
  logic          skip_empty;
  logic [AW:0]   skip_count;
  logic          overflow;
  logic          underflow;

  always #5 clk = ~clk;

  cnn_skip_fork #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_SIZE(FS)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .in(din),
    .out_main(out_main), .valid_out_main(valid_out_main), .frame_end_main(frame_end_main),
    .rd_en_skip(rd_en_skip), .out_skip(out_skip), .valid_out_skip(valid_out_skip),
    .skip_full(skip_full), .skip_empty(skip_empty), .skip_count(skip_count),
    .overflow(overflow), .underflow(underflow)
  );

  typedef struct {
    logic          rst;
    logic          vin;
    logic [DW-1:0] d;
    logic          rd;
    logic          e_vm;
    logic [DW-1:0] e_om;
    logic          e_fe;
    logic          e_vs;
    logic [DW-1:0] e_os;
    int            e_cnt;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  // Reference model: a plain queue of words plus a pixel counter.
  logic [DW-1:0] mq[$];
  int            m_fc;
  logic          m_vm, m_fe, m_vs, m_ovf, m_unf;
  logic [DW-1:0] m_om, m_os;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic vin, input logic [DW-1:0] d, input logic rd,
                     input logic vm, input logic [DW-1:0] om, input logic fe,
                     input logic vs, input logic [DW-1:0] os, input int cnt);
    vec_t v;
    v.rst = rst; v.vin = vin; v.d = d; v.rd = rd;
    v.e_vm = vm; v.e_om = om; v.e_fe = fe; v.e_vs = vs; v.e_os = os; v.e_cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic model_step(input logic rst, input logic vin, input logic [DW-1:0] d, input logic rd);
    bit rd_ok, wr_ok;
    if (rst) begin
      mq.delete();
      m_fc = 0; m_vm = 0; m_fe = 0; m_vs = 0; m_om = '0; m_os = '0; m_ovf = 0; m_unf = 0;
    end else begin
      rd_ok = rd && (mq.size() > 0);
      wr_ok = vin && ((mq.size() < DEPTH) || rd_ok);
      if (rd && mq.size() == 0) m_unf = 1;
      if (vin && !wr_ok) m_ovf = 1;
      m_vs = rd_ok;
      if (rd_ok) m_os = mq.pop_front();
      if (wr_ok) mq.push_back(d);
      m_vm = vin;
      m_fe = vin && (m_fc == FS - 1);
      if (vin) begin
        m_om = d;
        m_fc = (m_fc + 1) % FS;
      end
    end
  endtask

  task automatic cycle(input logic rst, input logic vin, input logic [DW-1:0] d, input logic rd);
    reset = rst; valid_in = vin; din = d; rd_en_skip = rd;
    model_step(rst, vin, d, rd);
    @(posedge clk);
    #1;
    chk("m_valid_out_main", DW'(valid_out_main), DW'(m_vm));
    chk("m_out_main", out_main, m_om);
    chk("m_frame_end", DW'(frame_end_main), DW'(m_fe));
    chk("m_valid_out_skip", DW'(valid_out_skip), DW'(m_vs));
    chk("m_out_skip", out_skip, m_os);
    chk("m_skip_count", DW'(skip_count), DW'(mq.size()));
    chk("m_skip_full", DW'(skip_full), DW'(mq.size() == DEPTH));
    chk("m_skip_empty", DW'(skip_empty), DW'(mq.size() == 0));
`ifdef CNN_SKIP_FORK_STATUS_EN
    chk("m_overflow", DW'(overflow), DW'(m_ovf));
    chk("m_underflow", DW'(underflow), DW'(m_unf));
`else
    chk("m_overflow_off", DW'(overflow), '0);
    chk("m_underflow_off", DW'(underflow), '0);
`endif
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; din = '0; rd_en_skip = 1'b0;

    // Four-word pass-through and drain.
    add(1,0,0,0, 0,0,0,0,0,0);
    add(0,1,32'h3F800000,0, 1,32'h3F800000,0,0,0,1);
    add(0,1,32'h40000000,0, 1,32'h40000000,0,0,0,2);
    add(0,1,32'h40400000,0, 1,32'h40400000,0,0,0,3);
    add(0,1,32'h40800000,0, 1,32'h40800000,1,0,0,4);
    add(0,0,0,1, 0,32'h40800000,0,1,32'h3F800000,3);
    add(0,0,0,1, 0,32'h40800000,0,1,32'h40000000,2);
    add(0,0,0,1, 0,32'h40800000,0,1,32'h40400000,1);
    add(0,0,0,1, 0,32'h40800000,0,1,32'h40800000,0);
    // Fill past full, full write+read, drain, empty read, empty write+read.
    add(1,0,0,0, 0,0,0,0,0,0);
    add(0,1,1,0, 1,1,0,0,0,1);
    add(0,1,2,0, 1,2,0,0,0,2);
    add(0,1,3,0, 1,3,0,0,0,3);
    add(0,1,4,0, 1,4,1,0,0,4);
    add(0,1,5,0, 1,5,0,0,0,4);
    add(0,1,9,1, 1,9,0,1,1,4);
    add(0,0,0,1, 0,9,0,1,2,3);
    add(0,0,0,1, 0,9,0,1,3,2);
    add(0,0,0,1, 0,9,0,1,4,1);
    add(0,0,0,1, 0,9,0,1,9,0);
    add(0,0,0,1, 0,9,0,0,9,0);
    add(0,1,7,1, 1,7,0,0,9,1);
    add(0,0,0,1, 0,7,0,1,7,0);
    // Ten continuous pixels: frame end on the 4th and 8th.
    add(1,0,0,0, 0,0,0,0,0,0);
    for (int k = 0; k < 10; k++)
      add(0,1,32'h100 + k,0, 1,32'h100 + k,(k == 3 || k == 7),0,0,(k + 1 < 4) ? k + 1 : 4);
    // Reset mid-frame, then a clean frame.
    add(1,0,0,0, 0,0,0,0,0,0);
    for (int k = 0; k < 3; k++)
      add(0,1,32'h200 + k,0, 1,32'h200 + k,0,0,0,k + 1);
    add(1,0,0,0, 0,0,0,0,0,0);
    for (int k = 0; k < 4; k++)
      add(0,1,32'h300 + k,0, 1,32'h300 + k,(k == 3),0,0,k + 1);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rst, vecs[i].vin, vecs[i].d, vecs[i].rd);
      chk($sformatf("v%0d_valid_out_main", i), DW'(valid_out_main), DW'(vecs[i].e_vm));
      chk($sformatf("v%0d_out_main", i), out_main, vecs[i].e_om);
      chk($sformatf("v%0d_frame_end", i), DW'(frame_end_main), DW'(vecs[i].e_fe));
      chk($sformatf("v%0d_valid_out_skip", i), DW'(valid_out_skip), DW'(vecs[i].e_vs));
      chk($sformatf("v%0d_out_skip", i), out_skip, vecs[i].e_os);
      chk($sformatf("v%0d_skip_count", i), DW'(skip_count), DW'(vecs[i].e_cnt));
    end

    // Fresh fill, then a write+read on full must not flag overflow.
    cycle(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) cycle(0, 1, 32'h50 + k, 0);
    cycle(0, 1, 32'h99, 1);
    chk("full_wr_rd_no_overflow", DW'(overflow), '0);
    chk("full_wr_rd_oldest", out_skip, 32'h50);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++)
      cycle(($urandom_range(0, 199) == 0), $urandom_range(0, 1), $urandom, $urandom_range(0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
